// File: rtl/ldst_fp_conv_pipe.sv
// ldst_fp_conv_pipe: 2-stage multi-lane x87 extended <-> native FP converter with handshake and sticky flags
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_vld/in_rdy       request handshake; in_dir 0=load (ext->native), 1=store (native->ext)
//   in_tag, in_lane_en  request tag and per-lane enable
//   in_data             LANES x 81-bit lane operands
//   out_vld/out_rdy     result handshake; out_dir/out_tag echo the request
//   out_data/out_data_n converted lanes and their complement
//   out_flags           per lane {I,O,U}
//   sticky_flags        OR of emitted flags, cleared by sticky_clr
//
// Optional build macro: LDSTFP_DENORM_EN (gradual underflow instead of flush-to-zero)
module ldst_fp_conv_pipe #(
    parameter int LANES = 2,
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic               in_dir,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [LANES-1:0]   in_lane_en,
    input  logic [LANES*81-1:0] in_data,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic               out_dir,
    output logic [TAG_W-1:0]   out_tag,
    output logic [LANES*81-1:0] out_data,
    output logic [LANES*81-1:0] out_data_n,
    output logic [LANES*3-1:0] out_flags,
    output logic [2:0]         sticky_flags,
    input  logic               sticky_clr
);

    // Returns {I,O,U, 81-bit result}; a disabled lane yields all zeros.
    function automatic logic [83:0] conv(input logic dir, input logic en, input logic [80:0] d);
        logic [63:0] m;
        logic [15:0] ne;
        logic [2:0]  f;
        logic [80:0] r;
`ifdef LDSTFP_DENORM_EN
        logic [5:0]  lz;
        logic [6:0]  sh;
`endif
        m = d[63:0];
        f = 3'b000;
        r = '0;
        ne = '0;
        if (!dir) begin
            if (d[78:64] == 15'h0) begin
`ifdef LDSTFP_DENORM_EN
                if (m != 64'd0) begin
                    lz = '0;
                    for (int i = 0; i < 64; i++) if (m[i]) lz = 6'(63 - i);
                    ne = 16'h4001 - 16'(lz);
                    r = {d[79], ne[14:0], ne[15], m << lz};
                end
`else
                f[0] = |m;
`endif
            end else if (d[78:64] == 15'h7FFF) begin
                r = {d[79], 15'h7FFF, 1'b1, m};
                f[2] = |m[62:0];
            end else begin
                ne = {1'b0, d[78:64]} + 16'h4000;
                r = {d[79], ne[14:0], ne[15], m};
            end
        end else begin
            ne = {d[64], d[79:65]};
            if (ne <= 16'h4000) begin
                r = {1'b0, d[80], 79'd0};
                f[0] = |m;
`ifdef LDSTFP_DENORM_EN
                if (ne >= 16'h3FC1) begin
                    sh = 7'(16'h4001 - ne);
                    r[63:0] = m >> sh;
                    f[0] = (m & ~(64'hFFFF_FFFF_FFFF_FFFF << sh)) != 64'd0;
                end
`endif
            end else if (ne == 16'hFFFF) begin
                r = {1'b0, d[80], 15'h7FFF, m};
                f[2] = |m[62:0];
            end else if (ne >= 16'hBFFF) begin
                r = {1'b0, d[80], 15'h7FFF, 64'h8000_0000_0000_0000};
                f[1] = 1'b1;
            end else begin
                ne = ne - 16'h4000;
                r = {1'b0, d[80], ne[14:0], m};
            end
        end
        return en ? {f, r} : 84'd0;
    endfunction

    logic               r_s1_vld;
    logic               r_s1_dir;
    logic [TAG_W-1:0]   r_s1_tag;
    logic [LANES-1:0]   r_s1_en;
    logic [LANES*81-1:0] r_s1_data;
    logic               r_s2_vld;
    logic [LANES*81-1:0] w_conv;
    logic [LANES*3-1:0] w_flags;
    logic [2:0]         w_flag_or;
    logic               w_s1_adv;
    logic               w_s2_adv;

    assign w_s2_adv = ~r_s2_vld | out_rdy;
    assign w_s1_adv = ~r_s1_vld | w_s2_adv;
    assign in_rdy   = w_s1_adv;
    assign out_vld  = r_s2_vld;

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            assign {w_flags[3*l+:3], w_conv[81*l+:81]} = conv(r_s1_dir, r_s1_en[l], r_s1_data[81*l+:81]);
        end
    endgenerate

    always_comb begin
        w_flag_or = '0;
        for (int i = 0; i < LANES; i++) w_flag_or = w_flag_or | out_flags[3*i+:3];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld     <= 1'b0;
            r_s1_dir     <= 1'b0;
            r_s1_tag     <= '0;
            r_s1_en      <= '0;
            r_s1_data    <= '0;
            r_s2_vld     <= 1'b0;
            out_dir      <= 1'b0;
            out_tag      <= '0;
            out_data     <= '0;
            out_data_n   <= '1;
            out_flags    <= '0;
            sticky_flags <= '0;
        end else begin
            if (w_s1_adv) r_s1_vld <= in_vld;
            if (w_s1_adv && in_vld) begin
                r_s1_dir  <= in_dir;
                r_s1_tag  <= in_tag;
                r_s1_en   <= in_lane_en;
                r_s1_data <= in_data;
            end
            if (w_s2_adv) r_s2_vld <= r_s1_vld;
            // Payload only moves with a valid request so an idle output stays stable.
            if (w_s2_adv && r_s1_vld) begin
                out_dir    <= r_s1_dir;
                out_tag    <= r_s1_tag;
                out_data   <= w_conv;
                out_data_n <= ~w_conv;
                out_flags  <= w_flags;
            end
            sticky_flags <= sticky_clr ? 3'b000 : (out_vld && out_rdy) ? (sticky_flags | w_flag_or) : sticky_flags;
        end
    end

endmodule

// File: tb/tb_ldst_fp_conv_pipe.sv
// tb_ldst_fp_conv_pipe: directed scoreboard bench for ldst_fp_conv_pipe
module tb_ldst_fp_conv_pipe;

    localparam logic [63:0] ONE = 64'h8000_0000_0000_0000;
    localparam logic [63:0] QNAN = 64'hC000_0000_0000_0001;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic         dir;
        logic [7:0]   tag;
        logic [161:0] data;
        logic [5:0]   flags;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic         in_dir = 1'b0;
    logic [7:0]   in_tag = '0;
    logic [1:0]   in_lane_en = '0;
    logic [161:0] in_data = '0;
    logic         out_vld;
    logic         out_rdy = 1'b1;
    logic         out_dir;
    logic [7:0]   out_tag;
    logic [161:0] out_data;
    logic [161:0] out_data_n;
    logic [5:0]   out_flags;
    logic [2:0]   sticky_flags;
    logic         sticky_clr = 1'b0;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ldst_fp_conv_pipe #(.LANES(2), .TAG_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dir(in_dir), .in_tag(in_tag),
        .in_lane_en(in_lane_en), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dir(out_dir), .out_tag(out_tag),
        .out_data(out_data), .out_data_n(out_data_n), .out_flags(out_flags),
        .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
    );

    function automatic logic [80:0] ext(input logic s, input logic [14:0] e, input logic [63:0] m);
        return {1'b0, s, e, m};
    endfunction

    function automatic logic [80:0] nat(input logic s, input logic [15:0] e, input logic [63:0] m);
        return {s, e[14:0], e[15], m};
    endfunction

    task automatic check(input string name, input logic [161:0] obs, input logic [161:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && out_vld === 1'b1 && out_rdy === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_out", 162'(out_tag), 162'h1FF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_tag", 162'(out_tag), 162'(e.tag));
                check("out_dir", 162'(out_dir), 162'(e.dir));
                check("out_data", out_data, e.data);
                check("out_data_n", out_data_n, ~e.data);
                check("out_flags", 162'(out_flags), 162'(e.flags));
            end
        end
    end

    task automatic send(input logic dir, input logic [7:0] tag, input logic [1:0] en,
                        input logic [161:0] d, input logic [161:0] ed, input logic [5:0] ef);
        logic acc;
        in_vld = 1'b1; in_dir = dir; in_tag = tag; in_lane_en = en; in_data = d;
        acc = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            if (in_rdy === 1'b1) begin
                q.push_back('{dir: dir, tag: tag, data: ed, flags: ef});
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!acc) check("send_timeout", 162'(acc), 162'(1));
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (q.size() != 0 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        if (q.size() != 0) check("drain_timeout", 162'(q.size()), 162'(0));
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        @(negedge clk);
        check("sticky_cleared", 162'(sticky_flags), 162'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [161:0] e3;
        logic [5:0]   f3;
        logic [161:0] e5;
        logic [5:0]   f5;
        logic [161:0] e9;
`ifdef LDSTFP_DENORM_EN
        e3 = {ext(1, 15'h1000, 64'hABCD), ext(0, 15'h0, ONE >> 1)}; f3 = 6'b000_000;
        e5 = {nat(1, 16'h8000, ALL1), nat(0, 16'h3FC2, ONE)};       f5 = 6'b000_000;
        e9 = {ext(1, 15'h0, 64'h1), ext(0, 15'h0, 64'h0)};
`else
        e3 = {ext(1, 15'h1000, 64'hABCD), ext(0, 15'h0, 64'h0)};    f3 = 6'b000_001;
        e5 = {nat(1, 16'h8000, ALL1), 81'd0};                       f5 = 6'b000_001;
        e9 = {ext(1, 15'h0, 64'h0), ext(0, 15'h0, 64'h0)};
`endif
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_vld", 162'(out_vld), 162'(0));
        check("rst_out_data", out_data, 162'd0);
        check("rst_out_data_n", out_data_n, {162{1'b1}});
        check("rst_out_flags", 162'(out_flags), 162'(0));
        check("rst_sticky", 162'(sticky_flags), 162'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_rdy_after_rst", 162'(in_rdy), 162'(1));
        @(posedge clk); #1;

        // load 1.0 with latency check
        send(0, 8'h01, 2'b11, {ext(1, 15'h0, 64'h0), ext(0, 15'h3FFF, ONE)},
             {81'd0, nat(0, 16'h7FFF, ONE)}, 6'b000_000);
        in_vld = 1'b0;
        @(negedge clk);
        check("latency_c1", 162'(out_vld), 162'(0));
        @(negedge clk);
        check("latency_c2", 162'(out_vld), 162'(1));
        @(posedge clk); #1;

        send(1, 8'h02, 2'b11, {nat(1, 16'h3000, 64'h5), nat(0, 16'hC000, 64'h1234)},
             {ext(1, 15'h0, 64'h0), ext(0, 15'h7FFF, ONE)}, 6'b001_010);
        send(1, 8'h03, 2'b11, {nat(1, 16'h5000, 64'hABCD), nat(0, 16'h4000, ONE)}, e3, f3);
        in_vld = 1'b0;
        drain();

        // sticky accumulation and clear, with lane 1 disabled holding a NaN
        pulse_clr();
        send(0, 8'h04, 2'b01, {ext(1, 15'h7FFF, QNAN), ext(0, 15'h7FFF, QNAN)},
             {81'd0, nat(0, 16'hFFFF, QNAN)}, 6'b000_100);
        in_vld = 1'b0;
        drain();
        check("sticky_nan", 162'(sticky_flags), 162'(3'b100));
        pulse_clr();

        // clear wins over a same-cycle update
        sticky_clr = 1'b1;
        send(1, 8'h05, 2'b11, {nat(1, 16'h3000, 64'h5), nat(0, 16'hC000, 64'h1234)},
             {ext(1, 15'h0, 64'h0), ext(0, 15'h7FFF, ONE)}, 6'b001_010);
        in_vld = 1'b0;
        drain();
        sticky_clr = 1'b0;
        @(posedge clk); #1;
        check("sticky_clr_priority", 162'(sticky_flags), 162'(0));

        // boundary stream
        send(0, 8'h10, 2'b11, {ext(1, 15'h4000, ALL1), ext(0, 15'h0, 64'h1)}, e5, f5);
        send(1, 8'h11, 2'b11, {nat(0, 16'hBFFF, 64'h1), nat(1, 16'hFFFF, ONE)},
             {ext(0, 15'h7FFF, ONE), ext(1, 15'h7FFF, ONE)}, 6'b010_000);
        send(1, 8'h12, 2'b11, {nat(0, 16'h4001, 64'h7), nat(0, 16'hFFFE, 64'h0)},
             {ext(0, 15'h0001, 64'h7), ext(0, 15'h7FFF, ONE)}, 6'b000_010);
        send(0, 8'h13, 2'b11, {ext(0, 15'h7FFE, 64'h1), ext(1, 15'h7FFF, ONE)},
             {nat(0, 16'hBFFE, 64'h1), nat(1, 16'hFFFF, ONE)}, 6'b000_000);
        send(1, 8'h14, 2'b11, {nat(1, 16'h4000, 64'h3), nat(0, 16'h3FC1, ALL1)}, e9, 6'b001_001);
        in_vld = 1'b0;
        drain();

        // backpressure: consumer stalls for 3 cycles
        out_rdy = 1'b0;
        send(1, 8'hA0, 2'b01, {81'd0, nat(0, 16'h4001, 64'h7)}, {81'd0, ext(0, 15'h1, 64'h7)}, 6'b0);
        send(1, 8'hA1, 2'b01, {81'd0, nat(0, 16'h4002, 64'h8)}, {81'd0, ext(0, 15'h2, 64'h8)}, 6'b0);
        @(negedge clk);
        check("in_rdy_full", 162'(in_rdy), 162'(0));
        check("stall_out_vld", 162'(out_vld), 162'(1));
        check("stall_out_tag", 162'(out_tag), 162'(8'hA0));
        @(posedge clk); #1;
        out_rdy = 1'b1;
        send(1, 8'hA2, 2'b01, {81'd0, nat(0, 16'h4003, 64'h9)}, {81'd0, ext(0, 15'h3, 64'h9)}, 6'b0);
        send(1, 8'hA3, 2'b01, {81'd0, nat(0, 16'h4004, 64'hA)}, {81'd0, ext(0, 15'h4, 64'hA)}, 6'b0);
        in_vld = 1'b0;
        drain();

        // reset mid-stream
        send(0, 8'hB0, 2'b11, {ext(0, 15'h0, 64'h1), ext(0, 15'h0, 64'h1)}, 162'd0, 6'b0);
        send(0, 8'hB1, 2'b11, {ext(0, 15'h0, 64'h1), ext(0, 15'h0, 64'h1)}, 162'd0, 6'b0);
        in_vld = 1'b0;
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_vld", 162'(out_vld), 162'(0));
        check("midrst_in_rdy", 162'(in_rdy), 162'(1));
        check("midrst_data_n", out_data_n, {162{1'b1}});
        check("midrst_sticky", 162'(sticky_flags), 162'(0));
        @(posedge clk); #1;
        send(0, 8'hC0, 2'b11, {ext(1, 15'h0, 64'h0), ext(0, 15'h3FFF, ONE)},
             {81'd0, nat(0, 16'h7FFF, ONE)}, 6'b000_000);
        in_vld = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ldst_fp_conv_pipe.md
Name: ldst_fp_conv_pipe

Overview:
- Pipelined, multi-lane converter between the 80-bit x87 extended memory format and the 81-bit native FP register format, in both directions.
- Sits between the load/store data path and the FP register file.
- Adds over the single-lane combinational converters:
  - valid/ready handshake with backpressure
  - per-request direction and tag
  - per-lane exception flags, plus sticky flag accumulation

Parameters:
LANES, 2, number of independent conversion lanes per request
TAG_W, 8, width of request tag carried through the pipe

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_vld  input  1  request valid
in_rdy  output  1  request accepted when in_vld&in_rdy
in_dir  input  1  0=load (extended->native), 1=store (native->extended)
in_tag  input  TAG_W  request tag
in_lane_en  input  LANES  per-lane enable; disabled lanes output zero, no flags
in_data  input  LANES*81  lane i at [81*i+80:81*i]; load uses low 80 bits, bit 80 ignored
out_vld  output  1  result valid
out_rdy  input  1  consumer ready
out_dir  output  1  direction of result
out_tag  output  TAG_W  tag of result
out_data  output  LANES*81  native result (load) or {1'b0, extended} (store)
out_data_n  output  LANES*81  bitwise complement of out_data (dual-rail for register file)
out_flags  output  LANES*3  per lane {I,O,U}: invalid NaN, overflow, underflow/denormal
sticky_flags  output  3  OR of all emitted out_flags since last clear
sticky_clr  input  1  clears sticky_flags

Behaviour:
- Formats
  - Extended: sign e[79], exponent Ee=e[78:64], mantissa e[63:0] (explicit integer bit).
  - Native: sign n[80], 16-bit exponent Ne={n[64],n[79:65]}, mantissa n[63:0].
- Load (dir=0), per lane
  - Ee==0: result all zero (sign dropped), U=1 if mantissa!=0.
  - Ee==0x7FFF: Ne=0xFFFF, mantissa passed; I=1 if e[62:0]!=0.
  - Otherwise: Ne=Ee+0x4000, mantissa passed.
- Store (dir=1), per lane
  - Ne<=0x4000: extended zero with sign kept, U=1 unless input mantissa==0.
  - 0xBFFF<=Ne<=0xFFFE: Ee=0x7FFF, mantissa=0x8000_0000_0000_0000 (infinity), O=1.
  - Ne==0xFFFF: Ee=0x7FFF, mantissa passed; I=1 if n[62:0]!=0.
  - Otherwise: Ee=Ne-0x4000 (16-bit subtract, low 15 bits kept).
- Pipeline structure
  - S1 registers the input.
  - S2 registers the converted result and flags; S2 drives out_*.
  - Latency 2 cycles from accept to out_vld when unstalled; throughput 1 request/cycle.
- Handshake
  - S2 advances when ~s2_vld | out_rdy.
  - S1 advances when ~s1_vld | S2 advances.
  - in_rdy = ~s1_vld | S2 advances (combinational from out_rdy).
  - out_vld held with data/tag/flags stable until out_rdy.
  - No bubbles inserted when full and out_rdy continuously high.
- Sticky flags
  - Updated on each out_vld&out_rdy handshake by ORing out_flags across lanes.
  - sticky_clr has priority over a same-cycle update: result is cleared, that cycle's flags lost.
- Reset
  - Clears s1_vld, s2_vld, out_vld, sticky_flags.
  - out_data and out_flags reset to 0; out_data_n resets to all ones.
  - Reset mid-operation discards in-flight requests; in_rdy=1 in the cycle after reset deasserts.

Optional Feature:
LDSTFP_DENORM_EN
- Defined
  - Load, Ee==0 and mantissa!=0: normalised via leading-zero count lz; Ne=0x4001-lz-? is exactly Ne=0x4001-lz, mantissa<<lz; U=0.
  - Store, 0x4000-63<=Ne<=0x4000: shift=0x4001-Ne, mantissa>>shift (truncated), Ee=0.
  - Store, lost bits nonzero: U=1.
  - Ne below that range: flushed to zero with U=1 as base behaviour.
  - Latency unchanged; the LZC/shift sits in the S1->S2 stage.
- Undefined: flush-to-zero behaviour exactly as in Behaviour.

Test Plan:
- Load 1.0: Ee=0x3FFF, mant=0x8000000000000000 -> Ne=0x7FFF, same mantissa, flags 0, out_vld at cycle 2.
- Store Ne=0xC000 -> Ee=0x7FFF, mant=0x8000000000000000, O=1.
- Store Ne=0x3000 -> zero, U=1; with LDSTFP_DENORM_EN, store Ne=0x4000 mant=0x8000000000000000 -> Ee=0, mant=0x4000000000000000, U=0.
- Load Ee=0x7FFF mant=0xC000000000000001 -> Ne=0xFFFF, I=1, sticky_flags=3'b100 after handshake; sticky_clr -> 0.
- Stream of 4 requests, out_rdy low for 3 cycles -> in_rdy drops after 2 accepted, no loss or reorder, tags in order.
- in_lane_en=2'b01 with NaN in lane 1 -> lane 1 out_data=0, out_data_n all ones, flags 0; rst mid-stream -> out_vld=0 next cycle.
